// File: rtl/rr_arbiter.sv
// Registered N-port request/grant arbiter with fixed or round-robin priority and optional grant locking.
// Latency: requests sampled at a rising edge appear on grant/grant_valid/grant_encoded after that edge (1 cycle).
// Backpressure: none; a locked grant is held until request-drop or acknowledge releases it, then re-arbitrates with no bubble.

// Priority encoder: lowest set index wins when LSB_HIGH=1, highest set index otherwise.
module rr_arbiter_enc #(
    parameter int W        = 4,
    parameter bit LSB_HIGH = 1'b1,
    parameter int IW       = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan so that the preferred end of the vector is written last and wins.
    always_comb begin
        vld = |vec;
        idx = '0;
        if (LSB_HIGH) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (vec[i]) idx = i[IW-1:0];
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (vec[i]) idx = i[IW-1:0];
            end
        end
    end

endmodule

module rr_arbiter #(
    parameter int    PORTS        = 4,
    parameter int    ROUND_ROBIN  = 1,
    parameter int    BLOCK        = 0,
    parameter int    BLOCK_ACK    = 0,
    parameter string LSB_PRIORITY = "HIGH"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int IW       = $clog2(PORTS);
    localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");

    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] mask_nxt;
    logic [PORTS-1:0] masked;
    logic [PORTS-1:0] grant_nxt;
    logic             req_vld;
    logic             msk_vld;
    logic [IW-1:0]    req_idx;
    logic [IW-1:0]    msk_idx;
    logic [IW-1:0]    win_idx;
    logic             hold;

    assign masked = request & mask;

    rr_arbiter_enc #(.W(PORTS), .LSB_HIGH(LSB_HIGH), .IW(IW)) u_enc_req (
        .vec (request),
        .vld (req_vld),
        .idx (req_idx)
    );

    rr_arbiter_enc #(.W(PORTS), .LSB_HIGH(LSB_HIGH), .IW(IW)) u_enc_msk (
        .vec (masked),
        .vld (msk_vld),
        .idx (msk_idx)
    );

    // Hold decision on the registered grant; acknowledges to other ports are ignored by indexing with the grant.
    always_comb begin
        hold = 1'b0;
        if (BLOCK != 0 && grant_valid) begin
            if (BLOCK_ACK != 0) hold = ~acknowledge[grant_encoded];
            else                hold = request[grant_encoded];
        end
    end

    // Winner selection; an empty masked set falls back to the full request vector for wrap-around.
    always_comb begin
        win_idx = req_idx;
        if (ROUND_ROBIN != 0 && msk_vld) win_idx = msk_idx;
    end

    // One-hot grant and the rotation mask that excludes the winner and everything ahead of it.
    always_comb begin
        grant_nxt = '0;
        mask_nxt  = '0;
        grant_nxt[win_idx] = 1'b1;
        for (int k = 0; k < PORTS; k++) begin
            if (LSB_HIGH) mask_nxt[k] = (k > int'(win_idx));
            else          mask_nxt[k] = (k < int'(win_idx));
        end
    end

    // Grant and mask registers; idle cycles clear the grant but keep the mask so rotation resumes in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            mask          <= '1;
        end else if (!hold) begin
            if (req_vld) begin
                grant         <= grant_nxt;
                grant_valid   <= 1'b1;
                grant_encoded <= win_idx;
                mask          <= mask_nxt;
            end else begin
                grant         <= '0;
                grant_valid   <= 1'b0;
                grant_encoded <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: five instances (RR, fixed HIGH, fixed LOW, RR ack-locked, RR request-locked) on shared inputs.
// Expected grants are pushed per cycle into a queue and checked one cycle later by an independent monitor.
// Async reset is additionally checked mid-cycle, away from any clock edge.
module tb_rr_arbiter;

    typedef struct packed {
        logic [4:0]      chk;
        logic [4:0][3:0] exp;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] request;
    logic [3:0] acknowledge;
    logic [3:0] g [5];
    logic       v [5];
    logic [1:0] e [5];

    int   n_vec;
    int   n_bad;
    ent_t q[$];

    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK(0), .BLOCK_ACK(0), .LSB_PRIORITY("HIGH")) u_rr (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .grant(g[0]), .grant_valid(v[0]), .grant_encoded(e[0]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK(0), .BLOCK_ACK(0), .LSB_PRIORITY("HIGH")) u_fix_hi (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .grant(g[1]), .grant_valid(v[1]), .grant_encoded(e[1]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK(0), .BLOCK_ACK(0), .LSB_PRIORITY("LOW")) u_fix_lo (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .grant(g[2]), .grant_valid(v[2]), .grant_encoded(e[2]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK(1), .BLOCK_ACK(1), .LSB_PRIORITY("HIGH")) u_blk_ack (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .grant(g[3]), .grant_valid(v[3]), .grant_encoded(e[3]));
    rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK(1), .BLOCK_ACK(0), .LSB_PRIORITY("HIGH")) u_blk_req (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .grant(g[4]), .grant_valid(v[4]), .grant_encoded(e[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] enc_of(input logic [3:0] onehot);
        enc_of = 2'd0;
        for (int i = 0; i < 4; i++) if (onehot[i]) enc_of = i[1:0];
    endfunction

    // Monitor: one queue entry per cycle, compared after the edge that consumed its inputs.
    initial begin
        ent_t ent;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                ent = q.pop_front();
                for (int d = 0; d < 5; d++) begin
                    if (ent.chk[d]) begin
                        n_vec++;
                        if ({g[d], v[d], e[d]} !== {ent.exp[d], |ent.exp[d], enc_of(ent.exp[d])}) begin
                            n_bad++;
                            $display("FAIL dut%0d t=%0t: grant=%b valid=%b enc=%0d, required grant=%b valid=%b enc=%0d",
                                     d, $time, g[d], v[d], e[d], ent.exp[d], |ent.exp[d], enc_of(ent.exp[d]));
                        end
                    end
                end
            end
        end
    end

    // Apply one cycle of inputs and queue the grants expected after the next edge.
    task automatic step(input logic [3:0] r, input logic [3:0] a,
                        input int d1, input logic [3:0] g1,
                        input int d2 = -1, input logic [3:0] g2 = 4'b0);
        ent_t ent;
        @(negedge clk);
        #1;
        rst_n       = 1'b1;
        request     = r;
        acknowledge = a;
        ent = '0;
        ent.chk[d1] = 1'b1;
        ent.exp[d1] = g1;
        if (d2 >= 0) begin
            ent.chk[d2] = 1'b1;
            ent.exp[d2] = g2;
        end
        q.push_back(ent);
    endtask

    // Three cycles of reset with every instance expected idle.
    task automatic do_reset();
        ent_t ent;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            rst_n       = 1'b0;
            request     = 4'b0;
            acknowledge = 4'b0;
            ent = '0;
            ent.chk = 5'b11111;
            q.push_back(ent);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        request     = 4'b0;
        acknowledge = 4'b0;

        // Round-robin rotation with all requesters active, including wrap-around.
        do_reset();
        step(4'b1111, 4'b0, 0, 4'b0001);
        step(4'b1111, 4'b0, 0, 4'b0010);
        step(4'b1111, 4'b0, 0, 4'b0100);
        step(4'b1111, 4'b0, 0, 4'b1000);
        step(4'b1111, 4'b0, 0, 4'b0001);

        // Fixed priority: HIGH picks index 1, LOW picks index 3; idle and single-requester cases.
        for (int i = 0; i < 3; i++) step(4'b1010, 4'b0, 1, 4'b0010, 2, 4'b1000);
        step(4'b0000, 4'b0, 1, 4'b0000, 2, 4'b0000);
        step(4'b0001, 4'b0, 1, 4'b0001, 2, 4'b0001);
        step(4'b0001, 4'b0, 1, 4'b0001, 2, 4'b0001);

        // Idle retention: mask kept across empty cycles, rotation resumes after index 2.
        do_reset();
        step(4'b0100, 4'b0, 0, 4'b0100);
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b0, 0, 4'b0000);
        step(4'b1111, 4'b0, 0, 4'b1000);
        step(4'b1111, 4'b0, 0, 4'b0001);

        // Acknowledge-locked grant: held through request drop and wrong-port ack, released by own ack.
        do_reset();
        step(4'b0110, 4'b0000, 3, 4'b0010);
        step(4'b0110, 4'b0000, 3, 4'b0010);
        step(4'b0100, 4'b0000, 3, 4'b0010);
        step(4'b0100, 4'b0100, 3, 4'b0010);
        step(4'b0100, 4'b0010, 3, 4'b0100);
        step(4'b0100, 4'b0000, 3, 4'b0100);
        step(4'b0100, 4'b0100, 3, 4'b0100);
        step(4'b0100, 4'b0000, 3, 4'b0100);

        // Request-locked grant: held while request[0] stays high, moves on when it drops.
        do_reset();
        step(4'b0011, 4'b0, 4, 4'b0001);
        step(4'b0011, 4'b0, 4, 4'b0001);
        step(4'b0011, 4'b0, 4, 4'b0001);
        step(4'b0010, 4'b0, 4, 4'b0010);
        step(4'b0010, 4'b0, 4, 4'b0010);
        step(4'b0000, 4'b0, 4, 4'b0000);

        // Async reset while a grant is held: outputs must clear before any edge.
        do_reset();
        step(4'b0110, 4'b0, 3, 4'b0010);
        step(4'b0000, 4'b0, 3, 4'b0010);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 5; d++) begin
            n_vec++;
            if ({g[d], v[d], e[d]} !== 7'b0) begin
                n_bad++;
                $display("FAIL async_rst dut%0d: grant=%b valid=%b enc=%0d, required all zero",
                         d, g[d], v[d], e[d]);
            end
        end
        do_reset();
        step(4'b1100, 4'b0000, 3, 4'b0100);
        step(4'b1100, 4'b0000, 3, 4'b0100);
        step(4'b1100, 4'b0100, 3, 4'b1000);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
